// File: rtl/fsm_puerta_pkg.sv
// Shared types and constants for the fsm_puerta sliding-door controller.
// The optional motion timeout is enabled by defining FSM_PUERTA_TIMEOUT_EN.
package fsm_puerta_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam int unsigned UI_PRESENCE   = 0;
  localparam int unsigned UI_OPEN_LIM   = 1;
  localparam int unsigned UI_CLOSED_LIM = 2;
  localparam int unsigned UI_OBSTACLE   = 3;
  localparam int unsigned UI_FAULT_CLR  = 4;

  localparam int unsigned UO_MOTOR_OPEN  = 0;
  localparam int unsigned UO_MOTOR_CLOSE = 1;
  localparam int unsigned UO_LAMP        = 2;
  localparam int unsigned UO_FAULT       = 3;
  localparam int unsigned UO_STATE_LSB   = 4;

  localparam logic [15:0] HOLD_CYCLES_DEF  = 16'd1000;
  localparam logic [15:0] MOVE_TIMEOUT_DEF = 16'd4000;

  // Moore output pattern for a state; bit 7 is always 0.
  function automatic logic [7:0] decode_outputs(input state_e st);
    logic [7:0] o;
    o = 8'h00;
    o[UO_STATE_LSB +: 3] = st;
    case (st)
      ST_OPENING: o[UO_MOTOR_OPEN]  = 1'b1;
      ST_OPEN:    o[UO_LAMP]        = 1'b1;
      ST_CLOSING: o[UO_MOTOR_CLOSE] = 1'b1;
      ST_FAULT:   o[UO_FAULT]       = 1'b1;
      default:    o[UO_FAULT]       = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fsm_puerta_timer.sv
// Loadable down-counter; zero_o flags that the count is (or is about to become) zero
// after this cycle's load/decrement, so callers can act on the cycle the count expires.
module fsm_puerta_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fsm_puerta.sv
// Sliding-door controller tile: five-state Moore FSM with hold-open timer.
// Define FSM_PUERTA_TIMEOUT_EN to add a motion timeout that faults stuck motion.
module fsm_puerta
  import fsm_puerta_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES = HOLD_CYCLES_DEF
`ifdef FSM_PUERTA_TIMEOUT_EN
  , parameter logic [15:0] MOVE_TIMEOUT = MOVE_TIMEOUT_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] out_q;
  logic [7:0] out_d;

  logic presence_s;
  logic open_lim_s;
  logic closed_lim_s;
  logic obstacle_s;
  logic fault_clr_s;
  logic occupied_s;
  logic double_lim_s;
  logic hold_load_s;
  logic hold_dec_s;
  logic hold_zero_s;
  logic move_expire_s;
  logic unused_s;

  assign presence_s   = ui_in[UI_PRESENCE];
  assign open_lim_s   = ui_in[UI_OPEN_LIM];
  assign closed_lim_s = ui_in[UI_CLOSED_LIM];
  assign obstacle_s   = ui_in[UI_OBSTACLE];
  assign fault_clr_s  = ui_in[UI_FAULT_CLR];
  assign occupied_s   = presence_s | obstacle_s;
  assign double_lim_s = open_lim_s & closed_lim_s;
  assign unused_s     = &{1'b0, ui_in[7:5], uio_in};

  // Hold timer is primed throughout OPENING so it holds HOLD_CYCLES on entering OPEN.
  always_comb begin
    hold_load_s = 1'b0;
    hold_dec_s  = 1'b0;
    if (ena) begin
      hold_load_s = (state_q == ST_OPENING) || ((state_q == ST_OPEN) && occupied_s);
      hold_dec_s  = (state_q == ST_OPEN) && !occupied_s;
    end else begin
      hold_load_s = 1'b0;
      hold_dec_s  = 1'b0;
    end
  end

  fsm_puerta_timer #(.W(16)) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (hold_load_s),
    .load_val_i (HOLD_CYCLES),
    .dec_i      (hold_dec_s),
    .zero_o     (hold_zero_s)
  );

`ifdef FSM_PUERTA_TIMEOUT_EN
  logic move_load_s;
  logic move_dec_s;
  logic move_zero_s;
  logic moving_s;

  assign moving_s = (state_q == ST_OPENING) || (state_q == ST_CLOSING);

  // Motion timer restarts outside motion and when CLOSING reverses into OPENING.
  always_comb begin
    move_load_s = 1'b0;
    move_dec_s  = 1'b0;
    if (ena) begin
      move_load_s = !moving_s || ((state_q == ST_CLOSING) && occupied_s);
      move_dec_s  = moving_s && !move_load_s;
    end else begin
      move_load_s = 1'b0;
      move_dec_s  = 1'b0;
    end
  end

  fsm_puerta_timer #(.W(16)) u_move_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (move_load_s),
    .load_val_i (MOVE_TIMEOUT),
    .dec_i      (move_dec_s),
    .zero_o     (move_zero_s)
  );

  assign move_expire_s = move_dec_s & move_zero_s;
`else
  assign move_expire_s = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = state_q;
    end else if ((state_q != ST_FAULT) && double_lim_s) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          if (presence_s) state_d = ST_OPENING;
          else            state_d = ST_CLOSED;
        end
        ST_OPENING: begin
          if (open_lim_s)         state_d = ST_OPEN;
          else if (move_expire_s) state_d = ST_FAULT;
          else                    state_d = ST_OPENING;
        end
        ST_OPEN: begin
          if (!occupied_s && hold_zero_s) state_d = ST_CLOSING;
          else                            state_d = ST_OPEN;
        end
        ST_CLOSING: begin
          if (occupied_s)         state_d = ST_OPENING;
          else if (closed_lim_s)  state_d = ST_CLOSED;
          else if (move_expire_s) state_d = ST_FAULT;
          else                    state_d = ST_CLOSING;
        end
        ST_FAULT: begin
          if (fault_clr_s) state_d = ST_CLOSING;
          else             state_d = ST_FAULT;
        end
        default: state_d = ST_CLOSED;
      endcase
    end
    out_d = decode_outputs(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLOSED;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Motor drive is gated by ena without a clock delay.
  assign uo_out  = {out_q[7:2], out_q[1:0] & {2{ena}}};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_fsm_puerta.sv
// Scoreboard bench for fsm_puerta: a rule-level door model predicts uo_out per cycle.
module tb_fsm_puerta;

  localparam logic [15:0] HOLD = 16'd10;
  localparam int          TO   = 20;
`ifdef FSM_PUERTA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  fsm_puerta #(
    .HOLD_CYCLES(HOLD)
`ifdef FSM_PUERTA_TIMEOUT_EN
    , .MOVE_TIMEOUT(16'd20)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;
  logic [7:0] exp_q[$];

  // Door model: mode 0 shut, 1 opening, 2 open, 3 closing, 4 fault.
  int m_mode   = 0;
  int m_idle   = 0;
  int m_moving = 0;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 8'h%02h, expected 8'h%02h", name, n_step, got, want);
    end
  endtask

  function automatic logic [7:0] model_out(input logic en);
    logic [7:0] o;
    o = 8'(m_mode * 16);
    if (m_mode == 1 && en) o = o + 8'd1;
    if (m_mode == 3 && en) o = o + 8'd2;
    if (m_mode == 2)       o = o + 8'd4;
    if (m_mode == 4)       o = o + 8'd8;
    return o;
  endfunction

  task automatic model_step(input logic [7:0] ui, input logic en);
    bit pres, ol, cl, obs, clr;
    pres = ui[0]; ol = ui[1]; cl = ui[2]; obs = ui[3]; clr = ui[4];
    if (!en) return;
    if (m_mode != 4 && ol && cl) begin
      m_mode = 4;
    end else begin
      case (m_mode)
        0: if (pres) begin m_mode = 1; m_moving = 0; end
        1: begin
          if (ol) begin m_mode = 2; m_idle = 0; end
          else if (TO_EN && m_moving + 1 >= TO) m_mode = 4;
          else m_moving++;
        end
        2: begin
          if (pres || obs) m_idle = 0;
          else if (m_idle + 1 >= int'(HOLD)) begin m_mode = 3; m_moving = 0; end
          else m_idle++;
        end
        3: begin
          if (pres || obs) begin m_mode = 1; m_moving = 0; end
          else if (cl) m_mode = 0;
          else if (TO_EN && m_moving + 1 >= TO) m_mode = 4;
          else m_moving++;
        end
        4: if (clr) begin m_mode = 3; m_moving = 0; end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic step(input logic [7:0] ui, input logic en);
    @(negedge clk);
    ui_in  = ui;
    ena    = en;
    uio_in = 8'($urandom);
    model_step(ui, en);
    exp_q.push_back(model_out(en));
  endtask

  task automatic steps(input logic [7:0] ui, input int n);
    for (int i = 0; i < n; i++) step(ui, 1'b1);
  endtask

  // Monitor: one expected value per clock once stimulus is flowing.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_step++;
        check8("uo_out", uo_out, e);
        check8("uio_out", uio_out, 8'h00);
        check8("uio_oe", uio_oe, 8'h00);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ui;
    logic       en;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #12;
    check8("reset_uo_out", uo_out, 8'h00);
    check8("reset_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal cycle, then reopen on obstacle
    steps(8'h00, 2);
    step(8'h01, 1'b1);
    steps(8'h00, 3);
    step(8'h02, 1'b1);
    steps(8'h00, 10);
    steps(8'h00, 2);
    step(8'h04, 1'b1);
    step(8'h01, 1'b1);
    step(8'h02, 1'b1);
    steps(8'h00, 11);
    step(8'h08, 1'b1);
    // Hold extension
    step(8'h02, 1'b1);
    steps(8'h01, 50);
    steps(8'h00, 12);
    // Double limit and fault clear
    step(8'h06, 1'b1);
    steps(8'h00, 3);
    step(8'h10, 1'b1);
    step(8'h04, 1'b1);
    // Motion timeout
    step(8'h01, 1'b1);
    steps(8'h00, 25);
    step(8'h10, 1'b1);
    step(8'h02, 1'b1);
    steps(8'h00, 4);
    // Freeze with ena low mid-hold
    for (int i = 0; i < 5; i++) step(8'($urandom), 1'b0);
    steps(8'h00, 8);
    // Async reset mid-motion
    step(8'h04, 1'b1);
    step(8'h01, 1'b1);
    steps(8'h00, 2);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check8("async_reset", uo_out, 8'h00);
    m_mode = 0; m_idle = 0; m_moving = 0;
    @(negedge clk);
    rst_n = 1'b1;
    steps(8'h00, 2);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      ui = 8'($urandom) & 8'hE0;
      if ($urandom_range(15, 0) == 0) ui[0] = 1'b1;
      if ($urandom_range(5, 0) == 0)  ui[1] = 1'b1;
      if ($urandom_range(5, 0) == 0)  ui[2] = 1'b1;
      if ($urandom_range(31, 0) == 0) ui[3] = 1'b1;
      if ($urandom_range(7, 0) == 0)  ui[4] = 1'b1;
      en = ($urandom_range(15, 0) != 0);
      step(ui, en);
    end

    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
